keccak200_iota_state: RTL
=========================

// Module: keccak200_iota_state
// PURPOSE
//  Keccak-f[200] state register, iota step and round controller for the round-based, port-serial core.
//  - Loads 25 bytes serially, then runs 18 rounds at one cycle each: state <= iota(round_in, RC[rnd]).
//    round_in is the 200-bit output of the chi layer, whose input is the theta/rho/pi result of state_q.
//  - Then unloads 25 bytes serially. Sits downstream of chi and upstream of theta.
// PARAMETERS
//  NROUNDS  18  rounds per permutation (12+2*l, l=3); fixed for w=8
//  NBYTES   25  lanes (bytes) per state; fixed
// PORTS
//  clk        in   1    single clock; all flops rising-edge
//  rst        in   1    synchronous, active-high reset
//  din        in   8    serial input byte
//  din_valid  in   1    din is valid
//  din_ready  out  1    block accepts din (LOAD state)
//  dout       out  8    serial output byte
//  dout_valid out  1    dout is valid (UNLOAD state)
//  dout_ready in   1    consumer accepts dout
//  state_q    out  200  state register to theta; lane k=x+5y at bits [8k+7:8k]
//  round_in   in   200  chi-layer output for the current state_q
//  busy       out  1    high in ROUND
// BEHAVIOUR
//  - FSM states: LOAD, ROUND, UNLOAD. Counters: byte_cnt (5b, 0..24) and rnd (5b, 0..17).
//  - Reset (sync, rst=1 at edge): fsm=LOAD, byte_cnt=0, rnd=0, state_q=0.
//    Outputs after reset: din_ready=1, dout_valid=0, busy=0, dout=0x00.
//  - rst overrides everything, including mid-LOAD, mid-ROUND and mid-UNLOAD. Partial data is discarded.
//  - Handshakes: a transfer happens on an edge where valid&&ready=1.
//    - din_valid and din_ready do not depend on each other.
//    - dout holds until accepted.
//  - LOAD: on a din handshake, byte[byte_cnt] <= din and byte_cnt++.
//    The handshake with byte_cnt=24 sets byte_cnt=0 and rnd=0, and moves to ROUND.
//  - ROUND: each cycle state_q <= round_in, with byte0 ^= RC[rnd], and rnd++.
//    At rnd=17: after the update, fsm=UNLOAD and rnd=0. din is ignored.
//  - UNLOAD: dout = byte[byte_cnt] (combinational mux of the register).
//    On a handshake byte_cnt++. The handshake with byte_cnt=24 returns to LOAD with byte_cnt=0.
//    din_ready is 0 in that cycle.
//  - RC[0..17] = 01 82 8A 00 8B 01 81 09 8A 88 09 0A 8B 8B 89 03 02 80 (hex).
//  - Latency: last din handshake -> first dout_valid is exactly 18 cycles.
//  - Throughput: 25+18+25 = 68 cycles per block with ideal handshakes.
//  - state_q is only written in LOAD (on a handshake) and ROUND; it is held otherwise.
//  - Counters never exceed 24 or 17. No wrap-around is reachable outside the defined transitions.
// CONFIGURATION
//  KECCAK_XOR_ABSORB_EN
//   - defined: LOAD does byte[k] <= byte[k] ^ din (sponge absorb).
//     The state persists across blocks and is cleared only by rst.
//   - undefined: LOAD overwrites byte[k] <= din.
// STRUCTURE
//  - Shared package/include keccak200_pkg:
//    - constants NROUNDS and NBYTES
//    - FSM state encoding (LOAD/ROUND/UNLOAD)
//    - 18x8 RC table and the lane-index function k=x+5y
//  - One sub-module, keccak200_rc_rom: 5-bit rnd -> 8-bit RC (combinational case).
//  - FSM, counters and the state register stay in this module.
// TESTING
//  (Stub round_in = state_q unless stated.)
//  1. Reset, load 25x 0x00, hold dout_ready=1.
//     -> busy high 18 cycles; dout = 02, then 24x 00 (XOR of all RC = 0x02).
//  2. Load bytes 0x00..0x18.
//     -> dout byte0 = 0x02, bytes 1..24 = 0x01..0x18 unchanged.
//     -> first dout_valid exactly 18 cycles after the last din handshake.
//  3. Real theta/rho/pi/chi chain, zero input.
//     -> 25 output bytes match the golden Keccak-f[200] C model bit-exactly.
//  4. Backpressure: dout_ready toggles 0/1 each cycle; din_valid random 50%.
//     -> no byte lost or duplicated; dout stable while dout_ready=0; din_ready=0 outside LOAD.
//  5. Assert rst for one cycle at ROUND rnd=7 and again at UNLOAD byte_cnt=12.
//     -> next cycle: state_q=0, din_ready=1, dout_valid=0, busy=0; a fresh load then gives test-1 output.
//  6. KECCAK_XOR_ABSORB_EN defined; two back-to-back zero loads.
//     -> second result = permutation of the first result (golden-model check).
//     Undefined: both results are equal.

Source files
------------

// File: rtl/keccak200_pkg.sv
`default_nettype none
// ============================================================================
// keccak200_pkg : shared constants, FSM encoding, round constants, lane index
// Revision 1.0
// ============================================================================
package keccak200_pkg;

  localparam int NROUNDS = 18;
  localparam int NBYTES  = 25;
  localparam int CNT_W   = 5;
  localparam int LANE_W  = 8;
  localparam int STATE_W = NBYTES * LANE_W;

  typedef logic [1:0] fsm_t;
  localparam fsm_t ST_LOAD   = 2'd0;
  localparam fsm_t ST_ROUND  = 2'd1;
  localparam fsm_t ST_UNLOAD = 2'd2;

  localparam logic [7:0] RC_TABLE [NROUNDS] = '{
    8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
    8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80
  };

  function automatic int lane_idx(input int x, input int y);
    return x + 5 * y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keccak200_rc_rom.sv
`default_nettype none
// ============================================================================
// keccak200_rc_rom : round index -> 8-bit iota round constant
// Revision 1.0
// ============================================================================
module keccak200_rc_rom
  import keccak200_pkg::*;
(
  input  logic [4:0] rnd,
  output logic [7:0] rc
);

  always_comb begin
    rc = 8'h00;
    case (rnd)
      5'd0:    rc = RC_TABLE[0];
      5'd1:    rc = RC_TABLE[1];
      5'd2:    rc = RC_TABLE[2];
      5'd3:    rc = RC_TABLE[3];
      5'd4:    rc = RC_TABLE[4];
      5'd5:    rc = RC_TABLE[5];
      5'd6:    rc = RC_TABLE[6];
      5'd7:    rc = RC_TABLE[7];
      5'd8:    rc = RC_TABLE[8];
      5'd9:    rc = RC_TABLE[9];
      5'd10:   rc = RC_TABLE[10];
      5'd11:   rc = RC_TABLE[11];
      5'd12:   rc = RC_TABLE[12];
      5'd13:   rc = RC_TABLE[13];
      5'd14:   rc = RC_TABLE[14];
      5'd15:   rc = RC_TABLE[15];
      5'd16:   rc = RC_TABLE[16];
      5'd17:   rc = RC_TABLE[17];
      default: rc = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/keccak200_iota_state.sv
`default_nettype none
// ============================================================================
// keccak200_iota_state : Keccak-f[200] state register, iota and round control
// Option macro: KECCAK_XOR_ABSORB_EN (LOAD XORs din into the state)
// Revision 1.0
// ============================================================================
module keccak200_iota_state
  import keccak200_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [7:0]   dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [199:0] state_q,
  input  logic [199:0] round_in,
  output logic         busy
);

  fsm_t                r_fsm;
  fsm_t                w_fsm_nxt;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [CNT_W-1:0]    r_rnd;
  logic [STATE_W-1:0]  r_state;
  logic [STATE_W-1:0]  w_load_val;
  logic [STATE_W-1:0]  w_iota_val;
  logic [7:0]          w_rc;
  logic [7:0]          w_lane [NBYTES];
  logic                w_din_hs;
  logic                w_dout_hs;
  logic                w_last_byte;
  logic                w_last_rnd;

  keccak200_rc_rom u_rc_rom (
    .rnd (r_rnd),
    .rc  (w_rc)
  );

  assign w_din_hs    = (r_fsm == ST_LOAD)   && din_valid;
  assign w_dout_hs   = (r_fsm == ST_UNLOAD) && dout_ready;
  assign w_last_byte = (r_byte_cnt == CNT_W'(NBYTES - 1));
  assign w_last_rnd  = (r_rnd == CNT_W'(NROUNDS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= ST_LOAD;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_LOAD:   if (w_din_hs && w_last_byte)  w_fsm_nxt = ST_ROUND;
      ST_ROUND:  if (w_last_rnd)               w_fsm_nxt = ST_UNLOAD;
      ST_UNLOAD: if (w_dout_hs && w_last_byte) w_fsm_nxt = ST_LOAD;
      default:                                 w_fsm_nxt = ST_LOAD;
    endcase
  end

  // FSM outputs
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    busy       = 1'b0;
    case (r_fsm)
      ST_LOAD:   din_ready  = 1'b1;
      ST_ROUND:  busy       = 1'b1;
      ST_UNLOAD: dout_valid = 1'b1;
      default: begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_rnd      <= '0;
    end else begin
      case (r_fsm)
        ST_LOAD: begin
          if (w_din_hs) begin
            r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + CNT_W'(1);
            if (w_last_byte) r_rnd <= '0;
          end
        end
        ST_ROUND: begin
          r_rnd <= w_last_rnd ? '0 : r_rnd + CNT_W'(1);
        end
        ST_UNLOAD: begin
          if (w_dout_hs) r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + CNT_W'(1);
        end
        default: begin
          r_byte_cnt <= '0;
          r_rnd      <= '0;
        end
      endcase
    end
  end

  // Per-lane load value: only the lane addressed by byte_cnt takes din.
  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      localparam int K = lane_idx(x, y);
      logic [7:0] w_new;
`ifdef KECCAK_XOR_ABSORB_EN
      assign w_new = r_state[8*K +: 8] ^ din;
`else
      assign w_new = din;
`endif
      assign w_load_val[8*K +: 8] = (r_byte_cnt == CNT_W'(K)) ? w_new : r_state[8*K +: 8];
      assign w_lane[K]            = r_state[8*K +: 8];
    end
  end

  assign w_iota_val = {round_in[STATE_W-1:8], round_in[7:0] ^ w_rc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
    end else if (r_fsm == ST_ROUND) begin
      r_state <= w_iota_val;
    end else if (w_din_hs) begin
      r_state <= w_load_val;
    end
  end

  assign state_q = r_state;
  assign dout    = (r_fsm == ST_UNLOAD) ? w_lane[r_byte_cnt] : 8'h00;

endmodule
`default_nettype wire
